mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive dbus grants while ibus waits (range 1..15).
REQ-002 SHALL have parameter RR_EN, default 0: 0 = dbus-priority with starvation guard, 1 = strict alternation when both request.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ireq, input, ibus_req_t: instruction-fetch request (valid, addr).
REQ-006 SHALL have port iresp, output, ibus_resp_t: instruction response (addr_ok, data_ok, data).
REQ-007 SHALL have port dreq, input, dbus_req_t: data request (valid, addr, size, strobe, data).
REQ-008 SHALL have port dresp, output, dbus_resp_t: data response (addr_ok, data_ok, data).
REQ-009 SHALL have port oreq, output, cbus_req_t: shared memory-bus request (valid, is_write, size, addr, strobe, data, len, burst).
REQ-010 SHALL have port oresp, input, cbus_resp_t: shared memory-bus response (ready, last, data).

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; reset state IDLE.
REQ-012 In IDLE, SHALL evaluate ireq.valid/dreq.valid each cycle; if any valid, latch the winner's request fields into a hold register and enter GRANT_I or GRANT_D on the next edge.
REQ-013 Arbitration, RR_EN=0: dbus wins a tie unless the starve counter equals STARVE_LIMIT, in which case ibus wins.
REQ-014 Arbitration, RR_EN=1: on a tie, the requester not granted most recently wins; a last-owner flag, reset to ibus, makes dbus win the first tie after reset.
REQ-015 Starve counter (4 bits): increments on each dbus grant made while ireq.valid=1; clears on any ibus grant or whenever ireq.valid=0 in IDLE; saturates at STARVE_LIMIT.
REQ-016 oreq SHALL be driven only from the hold register: valid=1 in GRANT_I/GRANT_D, else all fields 0; first oreq.valid is one cycle after the winning request is seen in IDLE.
REQ-017 ibus conversion: is_write=0, size=MSIZE4, strobe=0, len=MLEN1, burst=AXI_BURST_FIXED.
REQ-018 dbus conversion: is_write=(strobe!=0), size/strobe/data copied, len=MLEN1, burst=AXI_BURST_FIXED.
REQ-019 Owner response: addr_ok=data_ok=oresp.ready, data=oresp.data, combinational in the grant state; non-owner response all 0.
REQ-020 On oresp.ready && oresp.last in GRANT state: return to IDLE next edge; no back-to-back grant, so one IDLE bubble always separates transactions.
REQ-021 Requester dropping valid mid-grant SHALL NOT abort: hold register keeps oreq stable until completion; the response is still pulsed to that port.
REQ-022 Request field changes during a grant SHALL NOT affect oreq.
REQ-023 oresp.ready in IDLE SHALL be ignored.

Reset
REQ-024 On reset assertion, SHALL immediately (asynchronously) enter IDLE, clear hold register, starve counter and last-owner flag; oreq.valid=0, iresp/dresp all 0.
REQ-025 Reset during a grant SHALL discard the transaction with no response pulse; first grant after release follows REQ-012.

Structure
REQ-026 arb_state_t enum and the hold-register struct SHALL live in the shared common package beside the cbus types.
REQ-027 Winner selection (REQ-013/014) SHALL be one combinational sub-module, mem_arbiter_pick; FSM, counters and the hold register stay in mem_arbiter.
REQ-028 core SHALL instantiate mem_arbiter between its ibus/dbus ports and the single cbus.

Verification
REQ-029 ireq.valid only, addr=0x8000_0000, oresp ready+last 3 cycles after grant -> oreq.valid 1 cycle later, is_write=0, size=MSIZE4; iresp.data_ok one cycle; FSM back to IDLE.
REQ-030 Both valid, RR_EN=0, dreq strobe=0xFF, addr=0x8000_1000 -> GRANT_D first, oreq.is_write=1; ibus granted after completion plus one IDLE cycle.
REQ-031 Both held valid, RR_EN=0, STARVE_LIMIT=4, zero-latency memory -> exactly 4 dbus grants, then 1 ibus grant, then counter 0.
REQ-032 RR_EN=1, both held valid -> grants alternate D,I,D,I starting with D after reset.
REQ-033 dreq.valid dropped and addr changed mid-grant -> oreq addr unchanged; dresp.data_ok pulses at completion; iresp stays 0.
REQ-034 reset asserted mid-GRANT_I between clock edges -> oreq.valid=0 same cycle; no iresp.data_ok pulse; after release, pending ibus gets a new grant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the ibus/dbus front ends and the single cbus memory port,
// plus the arbiter's FSM state and hold-register layout.
package mem_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
    } hold_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between ibus and dbus; purely combinational.
module mem_arbiter_pick #(
    parameter bit RR_EN = 1'b0
) (
    input  logic ivalid_i,
    input  logic dvalid_i,
    input  logic starve_hit_i,
    input  logic last_d_i,
    output logic pick_d_o
);

    always_comb begin
        pick_d_o = 1'b0;
        if (dvalid_i && !ivalid_i) begin
            pick_d_o = 1'b1;
        end else if (dvalid_i && ivalid_i) begin
            // Tie: alternate owners, or favour dbus until ibus has waited too long.
            pick_d_o = RR_EN ? !last_d_i : !starve_hit_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter folding ibus and dbus onto one cbus; oreq is driven only
// from a hold register captured at grant time, so requesters may change freely.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit RR_EN        = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state_q, state_d;
    hold_t      hold_q, hold_d;
    logic [3:0] starve_q, starve_d;
    logic       last_d_q, last_d_d;
    logic       pick_d;

    mem_arbiter_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .ivalid_i    (ireq.valid),
        .dvalid_i    (dreq.valid),
        .starve_hit_i(starve_q == LIMIT),
        .last_d_i    (last_d_q),
        .pick_d_o    (pick_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            starve_q <= '0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            starve_q <= starve_d;
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        starve_d = starve_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (!ireq.valid) begin
                    starve_d = '0;
                end
                if (ireq.valid || dreq.valid) begin
                    last_d_d = pick_d;
                    if (pick_d) begin
                        state_d         = GRANT_D;
                        hold_d.is_write = |dreq.strobe;
                        hold_d.size     = dreq.size;
                        hold_d.addr     = dreq.addr;
                        hold_d.strobe   = dreq.strobe;
                        hold_d.data     = dreq.data;
                        // Only a grant that leaves ibus waiting counts towards starvation.
                        if (ireq.valid && (starve_q != LIMIT)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        state_d         = GRANT_I;
                        hold_d.is_write = 1'b0;
                        hold_d.size     = MSIZE4;
                        hold_d.addr     = ireq.addr;
                        hold_d.strobe   = '0;
                        hold_d.data     = '0;
                        starve_d        = '0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oreq  = '0;
        iresp = '0;
        dresp = '0;
        if (state_q != IDLE) begin
            oreq.valid    = 1'b1;
            oreq.is_write = hold_q.is_write;
            oreq.size     = hold_q.size;
            oreq.addr     = hold_q.addr;
            oreq.strobe   = hold_q.strobe;
            oreq.data     = hold_q.data;
            oreq.len      = MLEN1;
            oreq.burst    = AXI_BURST_FIXED;
        end
        if (state_q == GRANT_I) begin
            iresp.addr_ok = oresp.ready;
            iresp.data_ok = oresp.ready;
            iresp.data    = oresp.data;
        end
        if (state_q == GRANT_D) begin
            dresp.addr_ok = oresp.ready;
            dresp.data_ok = oresp.ready;
            dresp.data    = oresp.data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one dbus-priority instance with a scripted
// memory and one round-robin instance with a zero-latency memory.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    dbus_req_t  dreq;
    ibus_resp_t iresp, iresp_r;
    dbus_resp_t dresp, dresp_r;
    cbus_req_t  oreq, oreq_r;
    cbus_resp_t oresp, oresp_r;

    logic  mem_auto, man_ready, man_last;
    word_t man_data;

    int    nvec = 0;
    int    nmis = 0;
    int    icnt = 0;
    int    dcnt = 0;
    addr_t gq[$];
    addr_t gq_r[$];

    localparam word_t AUTO_DATA = 64'h0123_4567_89AB_CDEF;
    localparam addr_t IADDR     = 64'h0000_0000_8000_0000;
    localparam addr_t DADDR     = 64'h0000_0000_8000_1000;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .RR_EN(1'b0)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iresp(iresp),
        .dreq(dreq), .dresp(dresp),
        .oreq(oreq), .oresp(oresp)
    );

    mem_arbiter #(.STARVE_LIMIT(4), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iresp(iresp_r),
        .dreq(dreq), .dresp(dresp_r),
        .oreq(oreq_r), .oresp(oresp_r)
    );

    always_comb begin
        oresp = '0;
        if (mem_auto) begin
            oresp.ready = oreq.valid;
            oresp.last  = oreq.valid;
            oresp.data  = AUTO_DATA;
        end else begin
            oresp.ready = man_ready;
            oresp.last  = man_last;
            oresp.data  = man_data;
        end
    end

    always_comb begin
        oresp_r       = '0;
        oresp_r.ready = oreq_r.valid;
        oresp_r.last  = oreq_r.valid;
        oresp_r.data  = AUTO_DATA;
    end

    always @(negedge clk) begin
        if (iresp.data_ok) icnt++;
        if (dresp.data_ok) dcnt++;
        if (oreq.valid) gq.push_back(oreq.addr);
        if (oreq_r.valid) gq_r.push_back(oreq_r.addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ireq      = '0;
        dreq      = '0;
        mem_auto  = 1'b0;
        man_ready = 1'b0;
        man_last  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    ib, db, s, s_r;
        addr_t g, e;

        reset     = 1'b1;
        ireq      = '0;
        dreq      = '0;
        mem_auto  = 1'b0;
        man_ready = 1'b1;
        man_last  = 1'b1;
        man_data  = 64'hFFFF_0000_FFFF_0000;
        ireq.valid = 1'b1;
        ireq.addr  = IADDR;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_oreq_valid", 64'(oreq.valid), 64'd0);
        chk("rst_iresp_ok", 64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
        chk("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        chk("rst_rr_oreq_valid", 64'(oreq_r.valid), 64'd0);

        // Single ibus read with a three-cycle memory.
        do_reset();
        ib = icnt; db = dcnt;
        ireq.valid = 1'b1;
        ireq.addr  = IADDR;
        @(negedge clk);
        chk("i_idle_no_valid", 64'(oreq.valid), 64'd0);
        tick();
        ireq.valid = 1'b0;
        @(negedge clk);
        chk("i_valid", 64'(oreq.valid), 64'd1);
        chk("i_is_write", 64'(oreq.is_write), 64'd0);
        chk("i_size", 64'(oreq.size), 64'(MSIZE4));
        chk("i_addr", oreq.addr, IADDR);
        chk("i_strobe", 64'(oreq.strobe), 64'd0);
        chk("i_len", 64'(oreq.len), 64'(MLEN1));
        chk("i_burst", 64'(oreq.burst), 64'(AXI_BURST_FIXED));
        chk("i_wait_ok", 64'(iresp.data_ok), 64'd0);
        tick();
        tick();
        man_ready = 1'b1; man_last = 1'b1; man_data = 64'hDEAD_BEEF_0000_1111;
        @(negedge clk);
        chk("i_data_ok", 64'(iresp.data_ok), 64'd1);
        chk("i_addr_ok", 64'(iresp.addr_ok), 64'd1);
        chk("i_data", iresp.data, 64'hDEAD_BEEF_0000_1111);
        chk("i_dresp_quiet", 64'(dresp.data_ok), 64'd0);
        tick();
        man_ready = 1'b0; man_last = 1'b0;
        @(negedge clk);
        chk("i_back_idle", 64'(oreq.valid), 64'd0);
        tick();
        chk("i_pulses", 64'(icnt - ib), 64'd1);
        chk("i_no_dpulse", 64'(dcnt - db), 64'd0);

        // Tie with dbus priority: dbus write first, ibus after one bubble.
        do_reset();
        ib = icnt; db = dcnt;
        ireq.valid  = 1'b1;
        ireq.addr   = IADDR;
        dreq.valid  = 1'b1;
        dreq.addr   = DADDR;
        dreq.strobe = 8'hFF;
        dreq.size   = MSIZE8;
        dreq.data   = 64'h1122_3344_5566_7788;
        tick();
        dreq.valid = 1'b0; man_ready = 1'b1; man_last = 1'b1; man_data = 64'h0000_0000_0000_00D1;
        @(negedge clk);
        chk("tie_d_valid", 64'(oreq.valid), 64'd1);
        chk("tie_d_write", 64'(oreq.is_write), 64'd1);
        chk("tie_d_addr", oreq.addr, DADDR);
        chk("tie_d_strobe", 64'(oreq.strobe), 64'hFF);
        chk("tie_d_size", 64'(oreq.size), 64'(MSIZE8));
        chk("tie_d_data", oreq.data, 64'h1122_3344_5566_7788);
        chk("tie_d_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("tie_d_rdata", dresp.data, 64'h0000_0000_0000_00D1);
        chk("tie_i_quiet", 64'(iresp.data_ok), 64'd0);
        tick();
        man_ready = 1'b0; man_last = 1'b0;
        @(negedge clk);
        chk("tie_bubble", 64'(oreq.valid), 64'd0);
        tick();
        ireq.valid = 1'b0; man_ready = 1'b1; man_last = 1'b1;
        @(negedge clk);
        chk("tie_i_valid", 64'(oreq.valid), 64'd1);
        chk("tie_i_addr", oreq.addr, IADDR);
        chk("tie_i_write", 64'(oreq.is_write), 64'd0);
        chk("tie_i_data_ok", 64'(iresp.data_ok), 64'd1);
        tick();
        man_ready = 1'b0; man_last = 1'b0;
        tick();
        chk("tie_dpulses", 64'(dcnt - db), 64'd1);
        chk("tie_ipulses", 64'(icnt - ib), 64'd1);

        // dbus drops valid and changes fields mid-grant; ready in IDLE is ignored.
        do_reset();
        ib = icnt; db = dcnt;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_2000;
        dreq.strobe = 8'h0F;
        dreq.size   = MSIZE4;
        dreq.data   = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        dreq.valid  = 1'b0;
        dreq.addr   = 64'h0000_0000_9000_0000;
        dreq.strobe = 8'h00;
        dreq.data   = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("hold_addr", oreq.addr, 64'h0000_0000_8000_2000);
        chk("hold_strobe", 64'(oreq.strobe), 64'h0F);
        chk("hold_write", 64'(oreq.is_write), 64'd1);
        chk("hold_data", oreq.data, 64'hAAAA_AAAA_AAAA_AAAA);
        tick();
        @(negedge clk);
        chk("hold_valid2", 64'(oreq.valid), 64'd1);
        chk("hold_addr2", oreq.addr, 64'h0000_0000_8000_2000);
        tick();
        man_ready = 1'b1; man_last = 1'b1;
        @(negedge clk);
        chk("hold_d_data_ok", 64'(dresp.data_ok), 64'd1);
        chk("hold_i_quiet", 64'(iresp.data_ok), 64'd0);
        tick();
        @(negedge clk);
        chk("idle_ready_valid", 64'(oreq.valid), 64'd0);
        chk("idle_ready_dok", 64'(dresp.data_ok), 64'd0);
        chk("idle_ready_iok", 64'(iresp.data_ok), 64'd0);
        tick();
        chk("idle_ready_stay", 64'(oreq.valid), 64'd0);
        man_ready = 1'b0; man_last = 1'b0;
        chk("hold_dpulses", 64'(dcnt - db), 64'd1);
        chk("hold_ipulses", 64'(icnt - ib), 64'd0);

        // dbus read (strobe 0) is not a write.
        do_reset();
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h0000_0000_8000_3000;
        dreq.strobe = 8'h00;
        dreq.size   = MSIZE2;
        tick();
        dreq.valid = 1'b0; man_ready = 1'b1; man_last = 1'b1;
        @(negedge clk);
        chk("dread_write", 64'(oreq.is_write), 64'd0);
        chk("dread_size", 64'(oreq.size), 64'(MSIZE2));
        tick();
        man_ready = 1'b0; man_last = 1'b0;

        // Reset between edges during GRANT_I.
        do_reset();
        ib = icnt;
        ireq.valid = 1'b1;
        ireq.addr  = 64'h0000_0000_8000_4000;
        tick();
        @(negedge clk);
        chk("rg_valid_before", 64'(oreq.valid), 64'd1);
        #2;
        reset = 1'b1; man_ready = 1'b1; man_last = 1'b1;
        #1;
        chk("rg_valid_async", 64'(oreq.valid), 64'd0);
        chk("rg_iok_async", 64'(iresp.data_ok), 64'd0);
        tick();
        tick();
        reset = 1'b0; man_ready = 1'b0; man_last = 1'b0;
        @(negedge clk);
        chk("rg_idle_after", 64'(oreq.valid), 64'd0);
        tick();
        @(negedge clk);
        chk("rg_regrant", 64'(oreq.valid), 64'd1);
        chk("rg_regrant_addr", oreq.addr, 64'h0000_0000_8000_4000);
        chk("rg_no_pulse", 64'(icnt - ib), 64'd0);
        tick();
        ireq.valid = 1'b0; man_ready = 1'b1; man_last = 1'b1;
        tick();
        man_ready = 1'b0; man_last = 1'b0;

        // Both held valid with zero-latency memory: starvation guard and round-robin.
        do_reset();
        mem_auto    = 1'b1;
        ireq.valid  = 1'b1;
        ireq.addr   = IADDR;
        dreq.valid  = 1'b1;
        dreq.addr   = DADDR;
        dreq.strobe = 8'hFF;
        dreq.size   = MSIZE8;
        s   = gq.size();
        s_r = gq_r.size();
        repeat (20) tick();
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        tick();
        tick();
        mem_auto = 1'b0;
        chk("starve_ngrants", 64'(gq.size() - s), 64'd10);
        for (int i = 0; i < 10; i++) begin
            g = (s + i < gq.size()) ? gq[s + i] : '1;
            e = (i == 4 || i == 9) ? IADDR : DADDR;
            chk($sformatf("starve_g%0d", i), g, e);
        end
        chk("rr_ngrants", 64'(gq_r.size() - s_r), 64'd10);
        for (int i = 0; i < 10; i++) begin
            g = (s_r + i < gq_r.size()) ? gq_r[s_r + i] : '1;
            e = (i % 2 == 0) ? DADDR : IADDR;
            chk($sformatf("rr_g%0d", i), g, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
